// File: rtl/tqvp_ws2812b_encoder.sv
// ---------------------------------------------------------------------------
// tqvp_ws2812b_encoder
//
// TinyQV user peripheral that drives a WS2812B LED chain. Software loads a
// G/R/B colour and an LED count, then writes START. The block sends one
// 24-bit GRB frame (MSB first) per LED on uo_out[1], using WS2812B
// pulse-width encoding. It then holds the line low for a latch period.
//
// Ports
//   clk        peripheral clock (64 MHz nominal)
//   rst_n      asynchronous active-low reset
//   ui_in      unused
//   uo_out     [1] = serial data out, all other bits 0
//   address    register address
//   data_write write strobe, data_in valid when high
//   data_in    write data
//   data_out   read data, combinational from address
//
// Register map
//   0x0 R   0x1 G   0x2 B   0x3 COUNT       (read/write)
//   0x4 START (write)   0xE clear DONE (write)
//   0xF STATUS (read) = {6'b0, DONE, BUSY}
// ---------------------------------------------------------------------------
module tqvp_ws2812b_encoder #(
  parameter int CLK_HZ       = 64000000,
  parameter int T0H_CYCLES   = 26,
  parameter int T1H_CYCLES   = 51,
  parameter int BIT_CYCLES   = 80,
  parameter int LATCH_CYCLES = 3840
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  // CLK_HZ only documents the clock that the cycle counts assume.
  localparam int unused_clk_hz = CLK_HZ;

  localparam logic [11:0] T0H       = 12'(T0H_CYCLES);
  localparam logic [11:0] T1H       = 12'(T1H_CYCLES);
  localparam logic [11:0] BIT_LAST   = 12'(BIT_CYCLES - 1);
  localparam logic [11:0] LATCH_LAST = 12'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIT   = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  logic unused_ui_in;
  assign unused_ui_in = ^ui_in;

  // Software-visible registers
  logic [7:0] reg_r, reg_g, reg_b, reg_count;

  // Serialiser state, current and next
  state_t      state, state_d;
  logic [11:0] cyc, cyc_d;
  logic [4:0]  bit_idx, bit_idx_d;
  logic [7:0]  remaining, remaining_d;
  logic [23:0] shift, shift_d;
  logic        busy, busy_d;
  logic        done, done_d;
  logic        dout, dout_d;

  logic start_wr, clear_wr;
  assign start_wr = data_write && (address == 4'h4);
  assign clear_wr = data_write && (address == 4'hE);

  // Register file
  // NOTE: state is written with non-blocking assignments only. Every flop then
  // sees the pre-edge values of the others, whatever order the code is in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_r     <= 8'h00;
      reg_g     <= 8'h00;
      reg_b     <= 8'h00;
      reg_count <= 8'h00;
    end else if (data_write) begin
      case (address)
        4'h0:    reg_r     <= data_in;
        4'h1:    reg_g     <= data_in;
        4'h2:    reg_b     <= data_in;
        4'h3:    reg_count <= data_in;
        default: ;
      endcase
    end
  end

  // Serialiser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cyc       <= 12'd0;
      bit_idx   <= 5'd0;
      remaining <= 8'd0;
      shift     <= 24'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dout      <= 1'b0;
    end else begin
      state     <= state_d;
      cyc       <= cyc_d;
      bit_idx   <= bit_idx_d;
      remaining <= remaining_d;
      shift     <= shift_d;
      busy      <= busy_d;
      done      <= done_d;
      dout      <= dout_d;
    end
  end

  // Next-state logic. dout_d is derived from the current bit position, so the
  // registered line lags the counters by one cycle. The first high cycle
  // therefore appears one edge after START is accepted.
  // NOTE: every output of this block gets a default first. Without the
  // defaults, a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state;
    cyc_d       = cyc;
    bit_idx_d   = bit_idx;
    remaining_d = remaining;
    shift_d     = shift;
    busy_d      = busy;
    done_d      = done;
    dout_d      = 1'b0;

    if (clear_wr) done_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_wr && (reg_count != 8'd0) && !busy) begin
          remaining_d = reg_count;
          shift_d     = {reg_g, reg_r, reg_b};
          bit_idx_d   = 5'd23;
          cyc_d       = 12'd0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          state_d     = ST_BIT;
        end
      end

      ST_BIT: begin
        dout_d = (cyc < (shift[23] ? T1H : T0H));
        if (cyc == BIT_LAST) begin
          cyc_d   = 12'd0;
          shift_d = {shift[22:0], 1'b0};
          if (bit_idx == 5'd0) begin
            remaining_d = remaining - 8'd1;
            if (remaining == 8'd1) begin
              state_d = ST_LATCH;
            end else begin
              // Colours are sampled only here, so a write never tears a frame.
              shift_d   = {reg_g, reg_r, reg_b};
              bit_idx_d = 5'd23;
            end
          end else begin
            bit_idx_d = bit_idx - 5'd1;
          end
        end else begin
          cyc_d = cyc + 12'd1;
        end
      end

      ST_LATCH: begin
        if (cyc == LATCH_LAST) begin
          cyc_d   = 12'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cyc_d = cyc + 12'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign uo_out = {6'b000000, dout, 1'b0};

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0:    data_out = reg_r;
      4'h1:    data_out = reg_g;
      4'h2:    data_out = reg_b;
      4'h3:    data_out = reg_count;
      4'hF:    data_out = {6'b000000, done, busy};
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_ws2812b_encoder.sv
// ---------------------------------------------------------------------------
// Testbench for tqvp_ws2812b_encoder.
//
// Each run is captured one sample per cycle, taken on the falling edge.
// Sample k=0 is the first falling edge after the START write.
// Bit i of LED n then occupies samples 1 + n*1920 + i*80 .. +79.
// The latch window runs from the end of the last bit until BUSY falls.
// ---------------------------------------------------------------------------
module tb_tqvp_ws2812b_encoder;

  localparam int MAX_K  = 12000;
  localparam int LED_CY = 24 * 80;
  localparam int LATCH  = 3840;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  tqvp_ws2812b_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        wave [0:MAX_K-1];
  int          busy_len;
  logic [23:0] exp_frames [0:2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    address    = 4'hF;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    address = a;
    #1;
    check(tag, {24'd0, data_out}, {24'd0, exp});
  endtask

  // Called right after the START write. Records dout per cycle until BUSY
  // falls. It can also inject one register write at sample inj_k.
  task automatic run_capture(input int inj_k, input logic [3:0] inj_addr, input logic [7:0] inj_data);
    int k;
    busy_len = -1;
    k = 0;
    while (k < MAX_K && busy_len < 0) begin
      address    = 4'hF;
      data_write = 1'b0;
      #1;
      wave[k] = uo_out[1];
      if (k == 0) check("status_after_start", {24'd0, data_out}, 32'h01);
      if (data_out[0] == 1'b0) begin
        busy_len = k;
        check("status_at_end", {24'd0, data_out}, 32'h02);
      end
      if (k == inj_k) begin
        address    = inj_addr;
        data_in    = inj_data;
        data_write = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    address    = 4'hF;
    data_write = 1'b0;
    if (busy_len < 0) check("capture_timeout", 32'd0, 32'd1);
  endtask

  // Checks each bit's high width and that the bit starts high. Also checks
  // that the line stays low before the first bit and throughout the latch.
  task automatic analyze(input string tag, input int n);
    int ones;
    int base;
    check($sformatf("%s_lead_low", tag), {31'd0, wave[0]}, 32'd0);
    for (int led = 0; led < n; led++) begin
      for (int i = 0; i < 24; i++) begin
        base = 1 + led * LED_CY + i * 80;
        ones = 0;
        for (int c = 0; c < 80; c++) ones += (wave[base + c] === 1'b1) ? 1 : 0;
        check($sformatf("%s_led%0d_bit%0d_high", tag, led, i), ones,
              exp_frames[led][23 - i] ? 32'd51 : 32'd26);
        check($sformatf("%s_led%0d_bit%0d_rise", tag, led, i), {31'd0, wave[base]}, 32'd1);
      end
    end
    ones = 0;
    for (int k = 1 + n * LED_CY; k < busy_len && k < MAX_K; k++)
      ones += (wave[k] === 1'b0) ? 0 : 1;
    check($sformatf("%s_latch_low", tag), ones, 32'd0);
    check($sformatf("%s_busy_len", tag), busy_len, n * LED_CY + LATCH);
  endtask

  initial begin
    int any_busy;
    int any_dout;
    ui_in      = 8'h00;
    address    = 4'hF;
    data_write = 1'b0;
    data_in    = 8'h00;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state: every address reads zero and the line is low.
    for (int a = 0; a < 16; a++) rd_check($sformatf("reset_read_%0h", a), 4'(a), 8'h00);
    check("reset_uo_out", {24'd0, uo_out}, 32'h00);

    // Register readback
    wr(4'h1, 8'hA5);
    wr(4'h0, 8'h00);
    wr(4'h2, 8'hFF);
    wr(4'h3, 8'h01);
    rd_check("rd_g", 4'h1, 8'hA5);
    rd_check("rd_r", 4'h0, 8'h00);
    rd_check("rd_b", 4'h2, 8'hFF);
    rd_check("rd_count", 4'h3, 8'h01);

    // Single LED: G=A5 R=00 B=FF
    exp_frames[0] = 24'hA500FF;
    wr(4'h4, 8'h00);
    run_capture(-1, 4'h0, 8'h00);
    analyze("single", 1);

    // DONE handshake
    rd_check("status_done", 4'hF, 8'h02);
    wr(4'hE, 8'h5A);
    rd_check("status_cleared", 4'hF, 8'h00);

    // START with COUNT=0 is ignored.
    wr(4'h3, 8'h00);
    wr(4'h4, 8'h00);
    any_busy = 0;
    any_dout = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (data_out[0]) any_busy++;
      if (uo_out[1]) any_dout++;
    end
    check("count0_busy", any_busy, 32'd0);
    check("count0_dout", any_dout, 32'd0);
    rd_check("count0_status", 4'hF, 8'h00);

    // START while BUSY has no effect on the waveform or run length.
    wr(4'h3, 8'h01);
    wr(4'h4, 8'h00);
    run_capture(1000, 4'h4, 8'h00);
    analyze("restart", 1);

    // Three LEDs. R is rewritten during LED 0, so LEDs 1-2 carry the new R.
    wr(4'h1, 8'h12);
    wr(4'h0, 8'h34);
    wr(4'h2, 8'h56);
    wr(4'h3, 8'h03);
    exp_frames[0] = 24'h123456;
    exp_frames[1] = 24'h12C356;
    exp_frames[2] = 24'h12C356;
    wr(4'h4, 8'h00);
    run_capture(500, 4'h0, 8'hC3);
    analyze("multi", 3);

    // Reset during bit 10 of LED 1 (second LED), partway through the high phase
    wr(4'h4, 8'h00);
    repeat (1 + LED_CY + 10 * 80 + 5) @(negedge clk);
    #1;
    check("pre_reset_busy", {24'd0, data_out}, 32'h01);
    check("pre_reset_dout", {31'd0, uo_out[1]}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_dout", {24'd0, uo_out}, 32'h00);
    check("reset_status", {24'd0, data_out}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("reset_count_cleared", 4'h3, 8'h00);
    rd_check("reset_r_cleared", 4'h0, 8'h00);

    // A clean frame after reset
    wr(4'h1, 8'h3C);
    wr(4'h0, 8'h81);
    wr(4'h2, 8'h07);
    wr(4'h3, 8'h01);
    exp_frames[0] = 24'h3C8107;
    wr(4'h4, 8'h00);
    run_capture(-1, 4'h0, 8'h00);
    analyze("post_reset", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
